// File: rtl/dcache_axi_bridge.sv
// Purpose: memory-side responder that turns one D-cache line request into a 4-beat 32-bit AXI4 INCR burst.
// Latency: zero-wait read gives mvalid 6 cycles after accept; zero-wait write gives it one cycle after bvalid.
// Backpressure: one request in flight; every valid holds until its ready, and mvalid/mdata hold until dready.
module dcache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  // D-cache side
  input  logic         dvalid,
  input  logic [31:0]  addr,
  input  logic         wen,
  input  logic [127:0] ddata,
  input  logic         dready,
  output logic         mready,
  output logic         mvalid,
  output logic [127:0] mdata,
  // AXI read address / data
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address / data / response
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]    addr_q, addr_d;
  // Holds the writeback line, or collects the refill line beat by beat.
  logic [127:0]   line_q, line_d;

  // Burst shape and IDs never change; addresses come straight from the latched line address.
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd3;
  assign awlen   = 8'd3;
  assign arsize  = 3'd2;
  assign awsize  = 3'd2;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign mdata   = line_q;
  assign wdata   = line_q[{beat_cnt_q, 5'd0} +: 32];

  // Next-state, datapath updates and output decode; outputs depend only on registered state.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    mready     = 1'b0;
    mvalid     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wstrb      = 4'h0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (state_q)
      IDLE: begin
        mready = 1'b1;
        if (dvalid) begin
          // Masking keeps the whole address port in use while forcing line alignment.
          addr_d     = addr & 32'hFFFF_FFF0;
          line_d     = ddata;
          beat_cnt_d = 2'd0;
          state_d    = wen ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          line_d[{beat_cnt_q, 5'd0} +: 32] = rdata;
          beat_cnt_d = beat_cnt_q + 2'd1;
          // rlast alone ends the burst; a short burst leaves old words in the upper slots.
          if (rlast) state_d = RESP;
        end
      end
      WR_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        wvalid = 1'b1;
        wstrb  = 4'hF;
        wlast  = (beat_cnt_q == 2'd3);
        if (wready) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = RESP;
      end
      RESP: begin
        mvalid = 1'b1;
        if (dready) begin
          beat_cnt_d = 2'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      beat_cnt_q <= 2'd0;
      addr_q     <= 32'd0;
      line_q     <= 128'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: directed literal scenarios, then randomized traffic against a
// transaction-progress model that predicts every handshake output cycle by cycle.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         dvalid, wen, dready;
  logic [31:0]  addr;
  logic [127:0] ddata;
  logic         mready, mvalid;
  logic [127:0] mdata;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]   wstrb;

  always #5 clk = ~clk;

  dcache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .dvalid(dvalid), .addr(addr), .wen(wen), .ddata(ddata), .dready(dready),
    .mready(mready), .mvalid(mvalid), .mdata(mdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-progress model ----------------
  bit           m_busy, m_wr, m_adone, m_ddone, m_bdone;
  int           m_beats;
  logic [31:0]  m_addr;
  logic [127:0] m_line;

  logic e_ar, e_r, e_aw, e_w, e_b, e_m;
  assign e_ar = m_busy && !m_wr && !m_adone;
  assign e_r  = m_busy && !m_wr && m_adone && !m_ddone;
  assign e_aw = m_busy && m_wr && !m_adone;
  assign e_w  = m_busy && m_wr && m_adone && (m_beats < 4);
  assign e_b  = m_busy && m_wr && (m_beats == 4) && !m_bdone;
  assign e_m  = m_busy && (m_wr ? m_bdone : m_ddone);

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_wr = 0; m_adone = 0; m_ddone = 0; m_bdone = 0;
      m_beats = 0; m_addr = '0; m_line = '0;
    end else if (!m_busy) begin
      if (dvalid) begin
        m_busy = 1; m_wr = wen; m_addr = {addr[31:4], 4'h0}; m_line = ddata;
        m_adone = 0; m_ddone = 0; m_bdone = 0; m_beats = 0;
      end
    end else if (!m_adone) begin
      if (m_wr ? awready : arready) m_adone = 1;
    end else if (!m_wr && !m_ddone) begin
      if (rvalid) begin
        m_line[(m_beats % 4) * 32 +: 32] = rdata;
        m_beats++;
        if (rlast) m_ddone = 1;
      end
    end else if (m_wr && m_beats < 4) begin
      if (wready) m_beats++;
    end else if (m_wr && !m_bdone) begin
      if (bvalid) m_bdone = 1;
    end else if (dready) begin
      m_busy = 0;
      n_done++;
    end
  end

  // Compare every cycle, mid-period, while out of reset.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      chk("mready", mready, !m_busy);
      chk("mvalid", mvalid, e_m);
      chk("arvalid", arvalid, e_ar);
      chk("rready", rready, e_r);
      chk("awvalid", awvalid, e_aw);
      chk("wvalid", wvalid, e_w);
      chk("bready", bready, e_b);
      if (e_ar) chk("ar_fields", {arid, araddr, arlen, arsize, arburst}, {4'd1, m_addr, 8'd3, 3'd2, 2'b01});
      if (e_aw) chk("aw_fields", {awid, awaddr, awlen, awsize, awburst}, {4'd1, m_addr, 8'd3, 3'd2, 2'b01});
      if (e_w) chk("w_beat", {wdata, wstrb, wlast}, {m_line[m_beats * 32 +: 32], 4'hF, m_beats == 3});
      else chk("wlast_idle", wlast, 1'b0);
      if (e_m && !m_wr) chk("mdata", mdata, m_line);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    dvalid = 0; wen = 0; addr = '0; ddata = '0; dready = 0;
    arready = 0; rdata = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  logic [31:0] wv [4];
  logic [31:0] bp [4];

  initial begin
    resetn = 1'b0;
    clear_inputs();
    #3;
    chk("rst_mready", mready, 1'b1);
    chk("rst_valids", {mvalid, arvalid, awvalid, wvalid, wlast, rready, bready}, 7'd0);
    chk("rst_data", {mdata, araddr, awaddr, wdata}, 224'd0);
    cyc(); cyc();
    resetn = 1'b1;
    cyc();

    // Read refill, zero-wait slave.
    chk("rd_idle_mready", mready, 1'b1);
    dvalid = 1; wen = 0; addr = 32'h1000_0014;
    cyc();
    chk("rd_arvalid", arvalid, 1'b1);
    chk("rd_araddr_arlen", {araddr, arlen}, {32'h1000_0010, 8'd3});
    dvalid = 0; arready = 1;
    cyc();
    arready = 0;
    wv = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = wv[i]; rlast = (i == 3);
      cyc();
    end
    rvalid = 0; rlast = 0;
    chk("rd_mvalid_t6", mvalid, 1'b1);
    chk("rd_mdata", mdata, 128'h44444444_33333333_22222222_11111111);
    dready = 1;
    cyc();
    chk("rd_back_idle", {mready, mvalid}, 2'b10);
    dready = 0;

    // Writeback, zero-wait slave.
    wv = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    dvalid = 1; wen = 1; addr = 32'h2000_0020; ddata = {wv[3], wv[2], wv[1], wv[0]};
    awready = 1; wready = 1;
    cyc();
    chk("wr_awvalid", awvalid, 1'b1);
    chk("wr_awaddr", awaddr, 32'h2000_0020);
    dvalid = 0; wen = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("wr_wbeat", {wvalid, wdata, wstrb, wlast}, {1'b1, wv[i], 4'hF, i == 3});
      cyc();
    end
    awready = 0; wready = 0;
    chk("wr_bready", {bready, mvalid}, 2'b10);
    bvalid = 1;
    cyc();
    bvalid = 0;
    chk("wr_mvalid_after_b", mvalid, 1'b1);
    dready = 1;
    cyc();
    chk("wr_back_idle", mready, 1'b1);
    dready = 0;

    // Reset after two of four read beats, then a fresh read.
    dvalid = 1; addr = 32'h5000_0040;
    cyc();
    dvalid = 0; arready = 1;
    cyc();
    arready = 0; rvalid = 1; rdata = 32'hDEAD_0001;
    cyc();
    rdata = 32'hDEAD_0002;
    cyc();
    rvalid = 0;
    resetn = 0;
    #1;
    chk("mid_rst_mready", mready, 1'b1);
    chk("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready, mvalid}, 6'd0);
    cyc();
    resetn = 1;
    cyc();
    wv = '{32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
    dvalid = 1; addr = 32'h5000_0044;
    cyc();
    dvalid = 0; arready = 1;
    cyc();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = wv[i]; rlast = (i == 3);
      cyc();
    end
    rvalid = 0; rlast = 0;
    chk("post_rst_mdata", {mvalid, mdata}, {1'b1, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A});
    dready = 1;
    cyc();
    dready = 0;

    // Backpressure: late arready, gapped R beats, dready held low.
    bp = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978};
    dvalid = 1; addr = 32'h3000_0008;
    cyc();
    dvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ar_hold", {arvalid, araddr}, {1'b1, 32'h3000_0000});
      cyc();
    end
    arready = 1;
    cyc();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        rvalid = 0; rlast = 0;
        cyc();
        chk("bp_rready_gap", rready, 1'b1);
      end
      rvalid = 1; rdata = bp[i]; rlast = (i == 3);
      cyc();
    end
    rvalid = 0; rlast = 0;
    for (int j = 0; j < 3; j++) begin
      chk("bp_mvalid_hold", {mvalid, mdata}, {1'b1, bp[3], bp[2], bp[1], bp[0]});
      cyc();
    end
    chk("bp_mvalid_4th", mvalid, 1'b1);
    dready = 1;
    cyc();
    chk("bp_idle", {mready, mvalid}, 2'b10);
    dready = 0;

    // Busy rejection: write request presented during a read.
    dvalid = 1; wen = 0; addr = 32'h4000_0000;
    cyc();
    wen = 1; ddata = {4{32'h7777_7777}};
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("busy_reject", {mready, awvalid, arvalid}, 3'b001);
    end
    arready = 1;
    cyc();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'h5000_0000 + i; rlast = (i == 3);
      cyc();
    end
    rvalid = 0; rlast = 0;
    chk("busy_rd_line", {mvalid, mready, mdata}, {2'b10, 128'h50000003_50000002_50000001_50000000});
    dready = 1;
    cyc();
    dready = 0;
    chk("busy_then_idle", {mready, awvalid}, 2'b10);
    cyc();
    chk("busy_new_accept", {awvalid, awaddr}, {1'b1, 32'h4000_0000});
    dvalid = 0;

    // Randomized traffic, with an occasional reset.
    for (int c = 0; c < 5000; c++) begin
      if (resetn == 0) resetn = 1;
      else if ($urandom_range(0, 599) == 0) resetn = 0;
      dvalid  = ($urandom_range(0, 2) == 0);
      wen     = $urandom_range(0, 1) == 1;
      addr    = $urandom;
      ddata   = {$urandom, $urandom, $urandom, $urandom};
      arready = ($urandom_range(0, 2) == 0);
      awready = ($urandom_range(0, 2) == 0);
      wready  = $urandom_range(0, 1) == 1;
      dready  = ($urandom_range(0, 2) == 0);
      rdata   = $urandom;
      rvalid  = e_r && ($urandom_range(0, 1) == 1);
      rlast   = rvalid && (m_beats == 3);
      bvalid  = e_b && ($urandom_range(0, 1) == 1);
      cyc();
    end
    resetn = 1;
    clear_inputs();
    cyc();
    chk("random_progress", n_done > 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
